// File: rtl/lcd_image_sequencer_pkg.sv
// lcd_defs: shared LCD command codes and sequencer state encodings.
//   LCD_CMD_*  command codes presented on lcd_command
//   state_t    sequencer FSM states
package lcd_defs;

  localparam logic [2:0] LCD_CMD_NOP    = 3'd0;
  localparam logic [2:0] LCD_CMD_WINDOW = 3'd1;
  localparam logic [2:0] LCD_CMD_PIXEL  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WINDOW = 3'd2,
    ST_START  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/lcd_image_sequencer_pixel_pack.sv
// lcd_pixel_pack: combinational RGB to packed LCD pixel converter.
// Keeps the MSBs of each colour component (truncation) and zero-pads the top.
//   i_red/i_green/i_blue  ColorWidth-bit input components
//   o_pixel               {pad, r, g, b} packed output
module lcd_pixel_pack #(
  parameter int ColorWidth      = 8,
  parameter int PixelRedWidth   = 5,
  parameter int PixelGreenWidth = 6,
  parameter int PixelBlueWidth  = 5,
  parameter int PixelWidth      = 16
) (
  input  logic [ColorWidth-1:0] i_red,
  input  logic [ColorWidth-1:0] i_green,
  input  logic [ColorWidth-1:0] i_blue,
  output logic [PixelWidth-1:0] o_pixel
);

  localparam int PackedWidth = PixelRedWidth + PixelGreenWidth + PixelBlueWidth;

  // Component LSBs are dropped by design; fold them here so they are not flagged as dangling.
  logic w_unused;
  assign w_unused = &{1'b0, i_red, i_green, i_blue};

  always_comb begin
    o_pixel = '0;
    o_pixel[PackedWidth-1:0] = {i_red[ColorWidth-1 -: PixelRedWidth],
                                i_green[ColorWidth-1 -: PixelGreenWidth],
                                i_blue[ColorWidth-1 -: PixelBlueWidth]};
  end

endmodule

// File: rtl/lcd_image_sequencer.sv
// lcd_image_sequencer: walks an enable mask of image channels, issues a
// SetWindow per channel, then streams that channel's pixels as packed words.
//   i_clock/i_reset          clock, async active-high reset
//   i_refresh/i_continuous   pass start pulse, auto-restart mode
//   i_enable, i_win_*        per-channel enable and window geometry
//   i_in_*/o_in_*            per-channel image source handshake
//   o_lcd_*/i_lcd_ready      command stream to the LCD command engine
//   o_busy/o_error/o_pass_count  status
//
// state  | meaning
// IDLE   | waiting for refresh or pending request
// SELECT | pick lowest enabled channel, validate its window
// WINDOW | SetWindow command held until accepted
// START  | pulse in_start for the channel, load pixel count
// STREAM | forward pixels, drain last one, then back to SELECT
// DONE   | count the pass, restart or go idle
module lcd_image_sequencer
  import lcd_defs::*;
#(
  parameter int Channels        = 4,
  parameter int LcdWidth        = 80,
  parameter int LcdHeight       = 50,
  parameter int CoordinateWidth = 9,
  parameter int ColorWidth      = 8,
  parameter int PixelRedWidth   = 5,
  parameter int PixelGreenWidth = 6,
  parameter int PixelBlueWidth  = 5,
  parameter int PixelWidth      = 16,
  parameter int LcdCommandWidth = 3
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_refresh,
  input  logic                                  i_continuous,
  input  logic [Channels-1:0]                   i_enable,
  input  logic [Channels*CoordinateWidth-1:0]   i_win_x,
  input  logic [Channels*CoordinateWidth-1:0]   i_win_y,
  input  logic [Channels*CoordinateWidth-1:0]   i_win_w,
  input  logic [Channels*CoordinateWidth-1:0]   i_win_h,
  input  logic [Channels*3*ColorWidth-1:0]      i_in_data,
  input  logic [Channels-1:0]                   i_in_valid,
  input  logic [Channels-1:0]                   i_in_stop,
  output logic [Channels-1:0]                   o_in_ready,
  output logic [Channels-1:0]                   o_in_start,
  output logic [LcdCommandWidth-1:0]            o_lcd_command,
  output logic [CoordinateWidth-1:0]            o_lcd_x0,
  output logic [CoordinateWidth-1:0]            o_lcd_y0,
  output logic [CoordinateWidth-1:0]            o_lcd_x1,
  output logic [CoordinateWidth-1:0]            o_lcd_y1,
  output logic [PixelWidth-1:0]                 o_lcd_pixel,
  output logic                                  o_lcd_request,
  input  logic                                  i_lcd_ready,
  output logic                                  o_busy,
  output logic [Channels-1:0]                   o_error,
  output logic [15:0]                           o_pass_count
);

  localparam int CW = CoordinateWidth;
  localparam int NW = 2 * CoordinateWidth;
  localparam int IW = (Channels > 1) ? $clog2(Channels) : 1;
  localparam logic [CW:0] W_LIMIT = (CW+1)'(LcdWidth);
  localparam logic [CW:0] H_LIMIT = (CW+1)'(LcdHeight);

  state_t                     r_state, w_state_next;
  logic [Channels-1:0]        r_mask, r_error;
  logic [IW-1:0]              r_chan, w_sel;
  logic                       r_pending, r_accepting;
  logic [CW-1:0]              r_win_w, r_win_h;
  logic [NW-1:0]              r_count;
  logic [15:0]                r_pass_count;
  logic                       r_lcd_request;
  logic [LcdCommandWidth-1:0] r_lcd_command;
  logic [CW-1:0]              r_x0, r_y0, r_x1, r_y1;
  logic [PixelWidth-1:0]      r_pixel;

  logic [CW-1:0]              w_x, w_y, w_w, w_h;
  logic [CW:0]                w_x_end, w_y_end;
  logic                       w_win_bad, w_mask_empty;
  logic                       w_cur_valid, w_cur_stop;
  logic [3*ColorWidth-1:0]    w_cur_data;
  logic [PixelWidth-1:0]      w_pixel;
  logic                       w_out_free, w_take, w_accept, w_pass_start;

  // Lowest set mask bit wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    w_sel = '0;
    w_x   = '0;
    w_y   = '0;
    w_w   = '0;
    w_h   = '0;
    for (int c = Channels - 1; c >= 0; c--) begin
      if (r_mask[c]) begin
        w_sel = c[IW-1:0];
        w_x   = i_win_x[c*CW +: CW];
        w_y   = i_win_y[c*CW +: CW];
        w_w   = i_win_w[c*CW +: CW];
        w_h   = i_win_h[c*CW +: CW];
      end
    end
  end

  // One extra bit so an oversize window cannot wrap and look legal.
  assign w_x_end      = {1'b0, w_x} + {1'b0, w_w};
  assign w_y_end      = {1'b0, w_y} + {1'b0, w_h};
  assign w_win_bad    = (w_w == '0) || (w_h == '0) || (w_x_end > W_LIMIT) || (w_y_end > H_LIMIT);
  assign w_mask_empty = (r_mask == '0);

  always_comb begin
    w_cur_valid = 1'b0;
    w_cur_stop  = 1'b0;
    w_cur_data  = '0;
    for (int c = 0; c < Channels; c++) begin
      if (c[IW-1:0] == r_chan) begin
        w_cur_valid = i_in_valid[c];
        w_cur_stop  = i_in_stop[c];
        w_cur_data  = i_in_data[c*3*ColorWidth +: 3*ColorWidth];
      end
    end
  end

  lcd_pixel_pack #(
    .ColorWidth      (ColorWidth),
    .PixelRedWidth   (PixelRedWidth),
    .PixelGreenWidth (PixelGreenWidth),
    .PixelBlueWidth  (PixelBlueWidth),
    .PixelWidth      (PixelWidth)
  ) u_pack (
    .i_red   (w_cur_data[3*ColorWidth-1 -: ColorWidth]),
    .i_green (w_cur_data[2*ColorWidth-1 -: ColorWidth]),
    .i_blue  (w_cur_data[ColorWidth-1:0]),
    .o_pixel (w_pixel)
  );

  // Output register can take a new pixel when empty or being emptied this cycle.
  assign w_out_free   = !r_lcd_request || i_lcd_ready;
  assign w_take       = (r_state == ST_STREAM) && r_accepting && w_out_free;
  assign w_accept     = w_take && w_cur_valid;
  assign w_pass_start = ((r_state == ST_IDLE) && (i_refresh || r_pending)) ||
                        ((r_state == ST_DONE) && i_continuous);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = '0;
    o_in_start   = '0;
    case (r_state)
      ST_IDLE:   if (i_refresh || r_pending) w_state_next = ST_SELECT;
      ST_SELECT: begin
        if (w_mask_empty)    w_state_next = ST_DONE;
        else if (!w_win_bad) w_state_next = ST_WINDOW;
      end
      ST_WINDOW: if (i_lcd_ready) w_state_next = ST_START;
      ST_START: begin
        o_in_start[r_chan] = 1'b1;
        w_state_next       = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_take) o_in_ready[r_chan] = 1'b1;
        if (!r_accepting && w_out_free) w_state_next = ST_SELECT;
      end
      ST_DONE:   w_state_next = i_continuous ? ST_SELECT : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mask        <= '0;
      r_error       <= '0;
      r_chan        <= '0;
      r_pending     <= 1'b0;
      r_accepting   <= 1'b0;
      r_win_w       <= '0;
      r_win_h       <= '0;
      r_count       <= '0;
      r_pass_count  <= '0;
      r_lcd_request <= 1'b0;
      r_lcd_command <= LcdCommandWidth'(LCD_CMD_NOP);
      r_x0          <= '0;
      r_y0          <= '0;
      r_x1          <= '0;
      r_y1          <= '0;
      r_pixel       <= '0;
    end else begin
      // Any refresh seen while a pass runs collapses into a single pending request.
      if (r_state == ST_IDLE) r_pending <= 1'b0;
      else if (i_refresh)     r_pending <= 1'b1;

      if (w_pass_start) begin
        r_mask  <= i_enable;
        r_error <= '0;
      end

      case (r_state)
        ST_SELECT: begin
          if (!w_mask_empty) begin
            r_mask[w_sel] <= 1'b0;
            if (w_win_bad) begin
              r_error[w_sel] <= 1'b1;
            end else begin
              r_chan        <= w_sel;
              r_win_w       <= w_w;
              r_win_h       <= w_h;
              r_lcd_request <= 1'b1;
              r_lcd_command <= LcdCommandWidth'(LCD_CMD_WINDOW);
              r_x0          <= w_x;
              r_y0          <= w_y;
              r_x1          <= w_x_end[CW-1:0] - CW'(1);
              r_y1          <= w_y_end[CW-1:0] - CW'(1);
            end
          end
        end
        ST_WINDOW: if (i_lcd_ready) r_lcd_request <= 1'b0;
        ST_START: begin
          r_count     <= NW'(r_win_w) * NW'(r_win_h);
          r_accepting <= 1'b1;
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_pixel       <= w_pixel;
            r_lcd_command <= LcdCommandWidth'(LCD_CMD_PIXEL);
            r_lcd_request <= 1'b1;
            r_count       <= r_count - NW'(1);
            if (w_cur_stop) begin
              r_accepting <= 1'b0;
              if (r_count != NW'(1)) r_error[r_chan] <= 1'b1;
            end else if (r_count == NW'(1)) begin
              // Source still has pixels: stop consuming and flag it.
              r_accepting      <= 1'b0;
              r_error[r_chan]  <= 1'b1;
            end
          end else if (r_lcd_request && i_lcd_ready) begin
            r_lcd_request <= 1'b0;
          end
        end
        ST_DONE: r_pass_count <= r_pass_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_lcd_command = r_lcd_command;
  assign o_lcd_x0      = r_x0;
  assign o_lcd_y0      = r_y0;
  assign o_lcd_x1      = r_x1;
  assign o_lcd_y1      = r_y1;
  assign o_lcd_pixel   = r_pixel;
  assign o_lcd_request = r_lcd_request;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_error       = r_error;
  assign o_pass_count  = r_pass_count;

endmodule

// File: tb/tb_lcd_image_sequencer.sv
module tb_lcd_image_sequencer;

  localparam int CH = 2;
  localparam int CW = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              refresh = 1'b0;
  logic              continuous = 1'b0;
  logic [CH-1:0]     enable = '0;
  logic [CH*CW-1:0]  win_x = '0, win_y = '0, win_w = '0, win_h = '0;
  logic [CH*24-1:0]  in_data = '0;
  logic [CH-1:0]     in_valid = '0, in_stop = '0;
  logic [CH-1:0]     in_ready, in_start;
  logic [2:0]        lcd_command;
  logic [CW-1:0]     x0, y0, x1, y1;
  logic [15:0]       lcd_pixel;
  logic              lcd_request;
  logic              lcd_ready = 1'b1;
  logic              busy;
  logic [CH-1:0]     error;
  logic [15:0]       pass_count;

  lcd_image_sequencer #(.Channels(CH)) dut (
    .i_clock(clk), .i_reset(rst), .i_refresh(refresh), .i_continuous(continuous),
    .i_enable(enable), .i_win_x(win_x), .i_win_y(win_y), .i_win_w(win_w), .i_win_h(win_h),
    .i_in_data(in_data), .i_in_valid(in_valid), .i_in_stop(in_stop),
    .o_in_ready(in_ready), .o_in_start(in_start), .o_lcd_command(lcd_command),
    .o_lcd_x0(x0), .o_lcd_y0(y0), .o_lcd_x1(x1), .o_lcd_y1(y1), .o_lcd_pixel(lcd_pixel),
    .o_lcd_request(lcd_request), .i_lcd_ready(lcd_ready), .o_busy(busy),
    .o_error(error), .o_pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          wx[CH], wy[CH], ww[CH], wh[CH], stop_at[CH];
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] src_rgb(input int c, input int i);
    logic [7:0] r, g, b;
    r = 8'(i);
    g = 8'(i * 5 + c * 40);
    b = 8'(255 - i);
    return {r, g, b};
  endfunction

  function automatic logic [63:0] win_word(input int x, input int y, input int w, input int h);
    logic [8:0] a, b, e, d;
    a = 9'(x); b = 9'(y); e = 9'(x + w - 1); d = 9'(y + h - 1);
    return {9'b0, 3'd1, a, b, e, d, 16'h0};
  endfunction

  function automatic logic [63:0] pix_word(input int c, input int i);
    logic [23:0] rgb;
    logic [15:0] p;
    rgb = src_rgb(c, i);
    p   = {rgb[23:19], rgb[15:10], rgb[7:3]};
    return {9'b0, 3'd2, 36'b0, p};
  endfunction

  task automatic push_channel(input int c, input int npix);
    exp_q.push_back(win_word(wx[c], wy[c], ww[c], wh[c]));
    for (int i = 0; i < npix; i++) exp_q.push_back(pix_word(c, i));
  endtask

  task automatic set_win(input int c, input int x, input int y, input int w, input int h);
    wx[c] = x; wy[c] = y; ww[c] = w; wh[c] = h; stop_at[c] = w * h;
    win_x[c*CW +: CW] = 9'(x);
    win_y[c*CW +: CW] = 9'(y);
    win_w[c*CW +: CW] = 9'(w);
    win_h[c*CW +: CW] = 9'(h);
  endtask

  task automatic pulse_refresh();
    @(posedge clk); #1 refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_pass(input int target, input int budget);
    int n = 0;
    @(negedge clk);
    while (pass_count != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pass_wait_timeout", 64'(pass_count), 64'(target));
  endtask

  // LCD engine ready: held high or randomised, changed just after the edge.
  always begin
    @(posedge clk); #1;
    lcd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Image sources: start on in_start, emit one pixel per handshake, stop on stop_at.
  bit src_act[CH];
  int src_idx[CH];
  always begin
    bit acc[CH], st[CH];
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      acc[c] = in_ready[c] & in_valid[c];
      st[c]  = in_start[c];
      if (rst) begin src_act[c] = 1'b0; src_idx[c] = 0; end
    end
    @(posedge clk); #1;
    for (int c = 0; c < CH; c++) begin
      if (!rst) begin
        if (st[c]) begin
          src_act[c] = 1'b1;
          src_idx[c] = 0;
        end else if (acc[c]) begin
          if (src_idx[c] == stop_at[c] - 1) src_act[c] = 1'b0;
          src_idx[c]++;
        end
      end
      in_valid[c]        = src_act[c];
      in_stop[c]         = src_act[c] && (src_idx[c] == stop_at[c] - 1);
      in_data[c*24 +: 24] = src_rgb(c, src_idx[c]);
    end
  end

  // Scoreboard: every accepted LCD command is compared against the queue head.
  always begin
    logic [63:0] obs, held;
    bit held_v;
    @(negedge clk);
    if (rst || !lcd_request) begin
      held_v = 1'b0;
    end else begin
      if (lcd_command == 3'd1) obs = {9'b0, lcd_command, x0, y0, x1, y1, 16'h0};
      else                     obs = {9'b0, lcd_command, 36'b0, lcd_pixel};
      if (held_v) check("stall_stable", obs, held);
      if (lcd_ready) begin
        check("sb_underflow", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("lcd_cmd", obs, exp_q.pop_front());
        held_v = 1'b0;
      end else begin
        held   = obs;
        held_v = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_request", 64'(lcd_request), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_in_start", 64'(in_start), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_pass", 64'(pass_count), 64'd0);
    check("rst_cmd", 64'(lcd_command), 64'd0);
    check("rst_pixel", 64'(lcd_pixel), 64'd0);

    // Two full windows, ready held high
    enable = 2'b11;
    set_win(0, 10, 10, 12, 24);
    set_win(1, 30, 10, 24, 12);
    push_channel(0, 288);
    push_channel(1, 288);
    pulse_refresh();
    wait_idle(3000);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_pass", 64'(pass_count), 64'd1);
    check("t1_error", 64'(error), 64'd0);

    // Same with random back-pressure
    rand_ready = 1'b1;
    push_channel(0, 288);
    push_channel(1, 288);
    pulse_refresh();
    wait_idle(6000);
    rand_ready = 1'b0;
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t2_pass", 64'(pass_count), 64'd2);
    check("t2_error", 64'(error), 64'd0);

    // ch1 window overflows the panel width: skipped
    set_win(1, 75, 10, 10, 4);
    push_channel(0, 288);
    pulse_refresh();
    wait_idle(3000);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t3_pass", 64'(pass_count), 64'd3);
    check("t3_error", 64'(error), 64'd2);

    // ch0 stops early at pixel 100
    set_win(1, 30, 10, 24, 12);
    stop_at[0] = 100;
    push_channel(0, 100);
    push_channel(1, 288);
    pulse_refresh();
    wait_idle(3000);
    stop_at[0] = 288;
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t4_pass", 64'(pass_count), 64'd4);
    check("t4_error", 64'(error), 64'd1);

    // Continuous mode, refresh pulsed twice mid-pass, one extra pass from pending
    set_win(0, 0, 0, 4, 3);
    set_win(1, 5, 5, 2, 2);
    for (int p = 0; p < 4; p++) begin
      push_channel(0, 12);
      push_channel(1, 4);
    end
    @(posedge clk); #1 continuous = 1'b1;
    pulse_refresh();
    wait_pass(6, 500);
    @(posedge clk); #1 continuous = 1'b0;
    pulse_refresh();
    pulse_refresh();
    wait_idle(500);
    check("t5_pass_after_cont", 64'(pass_count), 64'd7);
    @(negedge clk);
    check("t5_pending_busy", 64'(busy), 64'd1);
    wait_idle(500);
    check("t5_pass_final", 64'(pass_count), 64'd8);
    repeat (20) @(negedge clk);
    check("t5_stays_idle", 64'(busy), 64'd0);
    check("t5_pass_stable", 64'(pass_count), 64'd8);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted mid-stream
    set_win(0, 10, 10, 0, 24);
    set_win(1, 30, 10, 24, 12);
    push_channel(1, 288);
    pulse_refresh();
    repeat (40) @(negedge clk);
    check("t6_pre_busy", 64'(busy), 64'd1);
    check("t6_pre_error", 64'(error), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("t6_rst_request", 64'(lcd_request), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_error", 64'(error), 64'd0);
    check("t6_rst_pass", 64'(pass_count), 64'd0);
    repeat (3) @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    set_win(0, 10, 10, 12, 24);
    push_channel(0, 288);
    push_channel(1, 288);
    pulse_refresh();
    wait_idle(3000);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t6_pass", 64'(pass_count), 64'd1);
    check("t6_error", 64'(error), 64'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
